// File: rtl/cnn_pkg.sv
// Shared types and default geometry for the CNN frame sequencer.
package cnn_pkg;

  localparam int unsigned CNN_IMG_W       = 32;
  localparam int unsigned CNN_IMG_H       = 32;
  localparam int unsigned CNN_N_PIX       = CNN_IMG_W * CNN_IMG_H;
  localparam int unsigned CNN_TIMEOUT_CYC = 50000;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StStream,
    StWaitRes,
    StDone
  } seq_state_e;

  typedef logic signed [47:0] lane_res_t;

endpackage

// File: rtl/cnn_frame_buffer.sv
// Simple dual-port frame store: one write port, one registered read port.
module cnn_frame_buffer #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Buffers one host frame, streams it to the CNN core, and returns the lane result
// (or a timeout marker) to the host.
module cnn_frame_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W       = cnn_pkg::CNN_IMG_W,
  parameter int unsigned IMG_H       = cnn_pkg::CNN_IMG_H,
  parameter int unsigned TIMEOUT_CYC = cnn_pkg::CNN_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic [7:0] host_data,
  output logic       start_signal,
  output logic       pixel_valid,
  output logic [7:0] pixel_in,
  input  logic       final_result_valid,
  input  lane_res_t  final_lane_result,
  output logic       res_valid,
  input  logic       res_ready,
  output lane_res_t  res_data,
  output logic       res_timeout,
  output logic       busy,
  output logic       proto_err
);

  localparam int unsigned N_PIX = IMG_W * IMG_H;
  localparam int unsigned AW    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int unsigned TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [AW-1:0] LastAddr = AW'(N_PIX - 1);
  localparam logic [TW-1:0] LastTmo  = TW'(TIMEOUT_CYC - 1);

  seq_state_e    state_q;
  logic [AW-1:0] wr_addr_q, rd_addr_q;
  logic          rd_last_q;
  logic [TW-1:0] tmo_q;
  logic          start_q, pv_q, res_valid_q, res_timeout_q, proto_err_q;
  lane_res_t     res_data_q;

  logic          accept, rd_en;
  logic [AW-1:0] waddr;
  logic [7:0]    rd_data;

  assign host_ready = (state_q == StIdle) || (state_q == StLoad);
  assign accept     = host_valid && host_ready;
  assign waddr      = (state_q == StIdle) ? '0 : wr_addr_q;
  // One read per STREAM cycle until the last address has been issued.
  assign rd_en      = (state_q == StStream) && !rd_last_q;

  cnn_frame_buffer #(
    .DEPTH (N_PIX),
    .AW    (AW)
  ) u_frame_buffer (
    .clk   (clk),
    .we    (accept),
    .waddr (waddr),
    .wdata (host_data),
    .re    (rd_en),
    .raddr (rd_addr_q),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      rd_last_q     <= 1'b0;
      tmo_q         <= '0;
      start_q       <= 1'b0;
      pv_q          <= 1'b0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_data_q    <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      pv_q    <= rd_en;
      if (final_result_valid && (state_q != StWaitRes)) proto_err_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            wr_addr_q <= AW'(1);
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          if (accept) begin
            if (wr_addr_q == LastAddr) begin
              wr_addr_q <= '0;
              start_q   <= 1'b1;
              state_q   <= StStart;
            end else begin
              wr_addr_q <= wr_addr_q + AW'(1);
            end
          end
        end
        StStart: begin
          rd_addr_q <= '0;
          rd_last_q <= 1'b0;
          state_q   <= StStream;
        end
        StStream: begin
          if (rd_en) begin
            if (rd_addr_q == LastAddr) rd_last_q <= 1'b1;
            else                       rd_addr_q <= rd_addr_q + AW'(1);
          end
          // Leave only once the final read has been presented as a strobe.
          if (rd_last_q && pv_q) begin
            tmo_q   <= '0;
            state_q <= StWaitRes;
          end
        end
        StWaitRes: begin
          if (final_result_valid) begin
            res_data_q    <= final_lane_result;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b1;
            state_q       <= StDone;
          end else if (tmo_q == LastTmo) begin
            res_data_q    <= '0;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            state_q       <= StDone;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        StDone: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign start_signal = start_q;
  assign pixel_valid  = pv_q;
  assign pixel_in     = pv_q ? rd_data : 8'd0;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_timeout  = res_timeout_q;
  assign busy         = (state_q != StIdle);
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench: stimulus queues expected pixels/results, negedge monitors check them.
module tb_cnn_frame_sequencer;
  import cnn_pkg::*;

  localparam int N_PIX   = 1024;
  localparam int TIMEOUT = 400;

  logic       clk, rst_n;
  logic       host_valid, host_ready;
  logic [7:0] host_data;
  logic       start_signal, pixel_valid;
  logic [7:0] pixel_in;
  logic       final_result_valid;
  lane_res_t  final_lane_result;
  logic       res_valid, res_ready, res_timeout, busy, proto_err;
  lane_res_t  res_data;

  cnn_frame_sequencer #(
    .IMG_W       (32),
    .IMG_H       (32),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .host_valid         (host_valid),
    .host_ready         (host_ready),
    .host_data          (host_data),
    .start_signal       (start_signal),
    .pixel_valid        (pixel_valid),
    .pixel_in           (pixel_in),
    .final_result_valid (final_result_valid),
    .final_lane_result  (final_lane_result),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_data           (res_data),
    .res_timeout        (res_timeout),
    .busy               (busy),
    .proto_err          (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic void check(input string name, input logic signed [63:0] act,
                                input logic signed [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  logic [7:0] exp_pix[$];
  lane_res_t  exp_rd[$];
  logic       exp_rt[$];
  int         exp_rl[$];

  int bytes_acc = 0;
  int run = 0;
  int frames_done = 0;
  int start_cyc = 0;
  int end_cyc = 0;
  bit res_seen = 0;
  logic [48:0] res_held;

  // Pixel-side monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (start_signal) begin
        start_cyc = cyc;
        check("start_after_load", bytes_acc, N_PIX);
      end
      if (pixel_valid) begin
        if (run == 0) check("first_strobe_lat", cyc - start_cyc, 2);
        if (exp_pix.size() == 0) check("pixel_unexpected", 1, 0);
        else check("pixel_data", pixel_in, exp_pix.pop_front());
        run = run + 1;
      end else begin
        check("pixel_idle_zero", pixel_in, 0);
        if (run != 0) begin
          check("strobe_run", run, N_PIX);
          run = 0;
          end_cyc = cyc;
          frames_done = frames_done + 1;
        end
      end
    end
  end

  // Result-side monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      res_seen = 0;
    end else if (res_valid) begin
      if (!res_seen) begin
        res_seen = 1;
        res_held = {res_timeout, res_data};
        if (exp_rd.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          check("res_data", res_data, exp_rd.pop_front());
          check("res_timeout", res_timeout, exp_rt.pop_front());
          check("res_latency", cyc - end_cyc, exp_rl.pop_front());
        end
      end else begin
        check("res_stable", {res_timeout, res_data}, res_held);
      end
    end else begin
      res_seen = 0;
    end
  end

  task automatic run_frame(input int seed, input bit half_duty, input int resp_d,
                           input lane_res_t val, input bit stray_frv, input int hold,
                           input bit abort);
    int iters, n0, t;
    bit acc;
    iters = 0;
    bytes_acc = 0;
    n0 = frames_done;
    if (!abort) begin
      if (resp_d >= 1 && resp_d <= TIMEOUT - 1) begin
        exp_rd.push_back(val); exp_rt.push_back(1'b0); exp_rl.push_back(resp_d + 1);
      end else begin
        exp_rd.push_back('0); exp_rt.push_back(1'b1); exp_rl.push_back(TIMEOUT);
      end
    end
    for (int k = 0; k < N_PIX; ) begin
      host_valid = half_duty ? ((iters % 2) == 0) : 1'b1;
      host_data = 8'((k + seed) % 256);
      final_result_valid = stray_frv && (k == 100);
      final_lane_result = 48'sd999;
      acc = host_valid && host_ready;
      @(posedge clk); #1;
      iters = iters + 1;
      if (acc) begin
        exp_pix.push_back(host_data);
        k = k + 1;
        bytes_acc = k;
      end
    end
    host_valid = 1'b0;
    final_result_valid = 1'b0;
    if (!half_duty) check("load_no_stall", iters, N_PIX);

    if (abort) begin
      t = 0;
      while (run < 500 && t < 3 * N_PIX) begin @(posedge clk); #1; t++; end
      check("reached_pixel_500", run >= 500, 1);
      rst_n = 1'b0;
      exp_pix.delete();
      #1;
      check("abort_pixel_valid", pixel_valid, 0);
      check("abort_host_ready", host_ready, 1);
      check("abort_busy", busy, 0);
      check("abort_res_valid", res_valid, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      return;
    end

    t = 0;
    while (frames_done == n0 && t < 3 * N_PIX) begin @(posedge clk); #1; t++; end
    check("stream_end", frames_done - n0, 1);
    if (resp_d >= 1) begin
      repeat (resp_d - 1) @(posedge clk);
      #1;
      final_result_valid = 1'b1;
      final_lane_result = val;
      @(posedge clk); #1;
      final_result_valid = 1'b0;
    end
    t = 0;
    while (!res_valid && t < TIMEOUT + 20) begin @(posedge clk); #1; t++; end
    check("res_arrive", res_valid, 1);
    repeat (hold) @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("res_valid_drop", res_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_host_ready", host_ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    host_valid = 1'b0;
    host_data = 8'd0;
    final_result_valid = 1'b0;
    final_lane_result = '0;
    res_ready = 1'b0;
    #2;
    check("rst_host_ready", host_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", start_signal, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_pixel_in", pixel_in, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_timeout", res_timeout, 0);
    check("rst_proto_err", proto_err, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp frame, result after 200 cycles.
    run_frame(0, 1'b0, 200, 48'sd12345, 1'b0, 0, 1'b0);
    // Core never answers.
    run_frame(7, 1'b0, -1, '0, 1'b0, 0, 1'b0);
    // Result lands on the final timeout cycle.
    run_frame(33, 1'b0, TIMEOUT - 1, -48'sd5, 1'b0, 0, 1'b0);
    // Host offers bytes every other cycle.
    run_frame(101, 1'b1, 10, 48'sh7FFF_0000_1234, 1'b0, 2, 1'b0);
    // Reset halfway through STREAM, then a clean frame.
    run_frame(55, 1'b0, 0, '0, 1'b0, 0, 1'b1);
    run_frame(200, 1'b0, 3, 48'sd42, 1'b0, 0, 1'b0);
    check("proto_err_clear", proto_err, 0);
    // Stray result during LOAD, host slow to consume.
    run_frame(9, 1'b0, 50, -48'sd777, 1'b1, 20, 1'b0);
    check("proto_err_set", proto_err, 1);
    check("exp_queue_drained", exp_rd.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
